ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute stage of the 5-stage RV32IM pipeline. Consumes the ID/EX pipeline register outputs and resolves RS1/RS2 forwarding from EX/MEM and MEM/WB. It computes single-cycle ALU results and branch targets, and runs M-extension multiply/divide on an iterative multi-cycle unit. While that unit is busy it asserts stall, which the hazard unit uses to freeze PC, IF/ID and ID/EX.

Parameters:
XLEN, 32, datapath width
MD_CYCLES, 32, iteration count of the multiply/divide unit

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
exPC  in  XLEN  PC from ID/EX
exRS1, exRS2  in  XLEN  register-file operands from ID/EX
exImmediate  in  XLEN  immediate from ID/EX
exALUSrc  in  1  1 = operand B is immediate
exALUCtrl  in  5  operation code (ex_pkg)
exReadDir1, exReadDir2  in  5  source register indices
memWriteDir  in  5  EX/MEM destination; memRegWrite in 1; memALUResult in XLEN
wbWriteDir  in  5  MEM/WB destination; wbRegWrite in 1; wbWriteData in XLEN
flush  in  1  kill current EX operation (branch taken)
aluResult  out  XLEN  result to EX/MEM
aluZero  out  1  aluResult == 0
branchTarget  out  XLEN  exPC + exImmediate
storeData  out  XLEN  forwarded RS2
stall  out  1  multi-cycle op not complete

Behaviour:
- Forwarding, per operand: EX/MEM when memRegWrite && memWriteDir != 0 && memWriteDir == dir. Otherwise MEM/WB under the same conditions. Otherwise the ID/EX value. EX/MEM has priority. x0 is never forwarded.
- opA = fwdRS1; opB = exALUSrc ? exImmediate : fwdRS2; storeData = fwdRS2.
- Single-cycle ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA (shift amount = opB[4:0]), SLT, SLTU.
  - Combinational, zero latency, stall = 0.
  - Undefined codes give aluResult = 0.
- Multi-cycle ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. FSM states are IDLE, BUSY, DONE.
  - IDLE with a multi-cycle op present:
    - stall = 1 combinationally.
    - At the clock edge: latch opA/opB, convert signed operands to magnitudes, record the result sign, load counter = MD_CYCLES-1, go to BUSY.
  - BUSY:
    - One shift-add (multiply) or restoring-subtract (divide) step per cycle; counter decrements; stall = 1.
    - At counter == 0, fix the result sign and register the result, then go to DONE.
  - DONE: stall = 0, aluResult = registered result. ID/EX advances at this edge and the FSM returns to IDLE.
  - Total: MD_CYCLES+1 stalled cycles before the DONE cycle.
  - Because operands are latched at start, forwarding-source changes during BUSY do not affect the result.
- Division special cases are resolved in IDLE, skipping BUSY, so the op reaches DONE after 1 stalled cycle:
  - Divisor = 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- MULH, MULHSU and MULHU return the upper 32 bits of the 64-bit product; MUL returns the lower 32 bits.
- flush: from any state, go to IDLE at the next edge and drop the result. stall is forced to 0 in the cycle flush is high.
- Reset (rst = 0), asynchronous, from any state including mid-BUSY:
  - FSM goes to IDLE, counter = 0, and the result and operand registers are cleared to 0.
  - stall is forced to 0.
  - Combinational outputs (aluResult, aluZero, branchTarget, storeData) follow their inputs.
- All arithmetic wraps modulo 2^XLEN; branchTarget ignores overflow.

Decomposition:
- ex_pkg holds:
  - the ALUCtrl encodings: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, MUL=10, MULH=11, MULHSU=12, MULHU=13, DIV=14, DIVU=15, REM=16, REMU=17;
  - the is_muldiv range constant;
  - the FSM state encoding.
- One sub-module, muldiv_unit, contains the FSM, counter and iterative datapath.
- Forwarding muxes and the single-cycle ALU stay in ex_stage.

Test Plan:
- ADD, opA=5, opB=0xFFFFFFFB, no forwarding -> aluResult=0, aluZero=1, stall=0 in the same cycle.
- RS1 dir 3 with memWriteDir=3 (memALUResult=0x10) and wbWriteDir=3 (wbWriteData=0x20), both RegWrite -> opA=0x10. Repeat with dir 0 -> the ID/EX value is used.
- DIV 0xFFFFFFF9 / 2 (-7/2) -> stall high for 33 cycles, then DONE with aluResult=0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF.
- DIVU x / 0 -> 1 stalled cycle, result 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MUL of the same operands -> 0x00000001.
- Start DIV; assert rst=0 asynchronously mid-BUSY (cycle 10) -> stall drops immediately and the FSM is IDLE. Separately, flush at cycle 5 -> IDLE next edge and no stale result on a following ADD.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, the
// multiply/divide opcode range and the multi-cycle unit FSM states.
package ex_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_e;

    // Codes in [MD_OP_FIRST, MD_OP_LAST] go to the iterative mul/div unit.
    localparam logic [4:0] MD_OP_FIRST = 5'd10;
    localparam logic [4:0] MD_OP_LAST  = 5'd17;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= MD_OP_FIRST) && (op <= MD_OP_LAST);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step
// per cycle on operand magnitudes, with the result sign fixed at the end.
// Handshake: start_i is held by the pipeline while stall_o is high; the
// result on result_o is meaningful only in the cycle state_o == MD_DONE,
// during which stall_o is low and the pipeline advances.
module muldiv_unit
    import ex_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic [XLEN-1:0] result_o,
    output md_state_e       state_o
);

    localparam int               CNT_W    = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);
    localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [XLEN-1:0]  opd_q, opd_d;       // multiplicand or divisor magnitude
    logic [XLEN-1:0]  hi_q, hi_d;         // product high half / partial remainder
    logic [XLEN-1:0]  lo_q, lo_d;         // multiplier bits / dividend-quotient
    logic [XLEN-1:0]  result_q, result_d;

    logic              sign_a, sign_b, is_div, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     add_sum, shifted, diff;
    logic [XLEN-1:0]   step_hi, step_lo, quo_fix, rem_fix, final_res;
    logic [2*XLEN-1:0] prod, prod_fix;

    // Decode the incoming op: which operands are signed, magnitudes, special cases
    always_comb begin
        is_div   = (op_i >= ALU_DIV);
        sign_a   = a_i[XLEN-1] & ((op_i == ALU_MULH) | (op_i == ALU_MULHSU) |
                                  (op_i == ALU_DIV)  | (op_i == ALU_REM));
        sign_b   = b_i[XLEN-1] & ((op_i == ALU_MULH) | (op_i == ALU_DIV) | (op_i == ALU_REM));
        mag_a    = sign_a ? -a_i : a_i;
        mag_b    = sign_b ? -b_i : b_i;
        div_zero = is_div & (b_i == '0);
        div_ovf  = ((op_i == ALU_DIV) | (op_i == ALU_REM)) & (a_i == XMIN) & (b_i == '1);
    end

    // One iteration step and the sign-corrected final result
    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, opd_q};
        if (op_q >= ALU_DIV) begin
            step_hi = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], ~diff[XLEN]};
        end else begin
            step_hi = add_sum[XLEN:1];
            step_lo = {add_sum[0], lo_q[XLEN-1:1]};
        end
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -step_lo : step_lo;
        rem_fix  = neg_q ? -step_hi : step_hi;
        case (op_q)
            ALU_MUL:                         final_res = prod_fix[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:               final_res = quo_fix;
            default:                         final_res = rem_fix;
        endcase
    end

    // FSM next state, datapath loads and the stall output
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opd_d    = opd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        stall_o  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    stall_o = 1'b1;
                    op_d    = op_i;
                    if (div_zero) begin
                        result_d = ((op_i == ALU_DIV) || (op_i == ALU_DIVU)) ? '1 : a_i;
                        state_d  = MD_DONE;
                    end else if (div_ovf) begin
                        result_d = (op_i == ALU_DIV) ? XMIN : '0;
                        state_d  = MD_DONE;
                    end else begin
                        neg_d   = (op_i == ALU_REM) ? sign_a : (sign_a ^ sign_b);
                        opd_d   = is_div ? mag_b : mag_a;
                        lo_d    = is_div ? mag_a : mag_b;
                        hi_d    = '0;
                        cnt_d   = CNT_LAST;
                        state_d = MD_BUSY;
                    end
                end
            end
            MD_BUSY: begin
                stall_o = 1'b1;
                hi_d    = step_hi;
                lo_d    = step_lo;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d    = '0;
                    result_d = final_res;
                    state_d  = MD_DONE;
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        if (flush_i) begin
            state_d  = MD_IDLE;
            result_d = '0;
            stall_o  = 1'b0;
        end
        if (!rst) begin
            stall_o = 1'b0;
        end
    end

    // State and datapath registers, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opd_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opd_q    <= opd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;
    assign state_o  = state_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, branch target and the
// iterative multiply/divide unit whose busy time stalls the front end.
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] exPC,
    input  logic [XLEN-1:0] exRS1,
    input  logic [XLEN-1:0] exRS2,
    input  logic [XLEN-1:0] exImmediate,
    input  logic            exALUSrc,
    input  logic [4:0]      exALUCtrl,
    input  logic [4:0]      exReadDir1,
    input  logic [4:0]      exReadDir2,
    input  logic [4:0]      memWriteDir,
    input  logic            memRegWrite,
    input  logic [XLEN-1:0] memALUResult,
    input  logic [4:0]      wbWriteDir,
    input  logic            wbRegWrite,
    input  logic [XLEN-1:0] wbWriteData,
    input  logic            flush,
    output logic [XLEN-1:0] aluResult,
    output logic            aluZero,
    output logic [XLEN-1:0] branchTarget,
    output logic [XLEN-1:0] storeData,
    output logic            stall
);

    localparam int SH_W = $clog2(XLEN);

    logic [XLEN-1:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_res, md_result;
    logic [SH_W-1:0] shamt;
    logic            md_op, md_stall;
    md_state_e       md_state;

    // Forwarding: EX/MEM beats MEM/WB, and x0 is never forwarded
    always_comb begin
        fwd_rs1 = exRS1;
        if (memRegWrite && (memWriteDir != 5'd0) && (memWriteDir == exReadDir1)) begin
            fwd_rs1 = memALUResult;
        end else if (wbRegWrite && (wbWriteDir != 5'd0) && (wbWriteDir == exReadDir1)) begin
            fwd_rs1 = wbWriteData;
        end
        fwd_rs2 = exRS2;
        if (memRegWrite && (memWriteDir != 5'd0) && (memWriteDir == exReadDir2)) begin
            fwd_rs2 = memALUResult;
        end else if (wbRegWrite && (wbWriteDir != 5'd0) && (wbWriteDir == exReadDir2)) begin
            fwd_rs2 = wbWriteData;
        end
    end

    assign op_a  = fwd_rs1;
    assign op_b  = exALUSrc ? exImmediate : fwd_rs2;
    assign shamt = op_b[SH_W-1:0];
    assign md_op = is_muldiv(exALUCtrl);

    // Single-cycle ALU; unknown codes produce zero
    always_comb begin
        case (exALUCtrl)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default:  alu_res = '0;
        endcase
    end

    muldiv_unit #(
        .XLEN      (XLEN),
        .MD_CYCLES (MD_CYCLES)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_op),
        .op_i     (exALUCtrl),
        .a_i      (op_a),
        .b_i      (op_b),
        .flush_i  (flush),
        .stall_o  (md_stall),
        .result_o (md_result),
        .state_o  (md_state)
    );

    // Result select: mul/div results only surface in the DONE cycle
    always_comb begin
        if (md_op) begin
            aluResult = (md_state == MD_DONE) ? md_result : '0;
        end else begin
            aluResult = alu_res;
        end
    end

    assign aluZero      = (aluResult == '0);
    assign branchTarget = exPC + exImmediate;
    assign storeData    = fwd_rs2;
    assign stall        = md_stall;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: randomized and directed instructions, an arithmetic
// reference model feeding an expected queue, and a negedge monitor.
module tb_ex_stage;
    import ex_pkg::*;

    localparam int XLEN      = 32;
    localparam int MD_CYCLES = 32;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] pc, rs1, rs2, imm;
        logic        alusrc;
        logic [4:0]  d1, d2, mdir, wdir;
        logic        mrw, wrw;
        logic [31:0] mres, wdata;
    } stim_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] result, store, target;
        int          stalls;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] exPC, exRS1, exRS2, exImmediate, memALUResult, wbWriteData;
    logic        exALUSrc, memRegWrite, wbRegWrite, flush;
    logic [4:0]  exALUCtrl, exReadDir1, exReadDir2, memWriteDir, wbWriteDir;
    logic [31:0] aluResult, branchTarget, storeData;
    logic        aluZero, stall;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stall_cnt = 0;
    logic instr_valid = 1'b0;
    logic accepted = 1'b0;

    ex_stage #(.XLEN(XLEN), .MD_CYCLES(MD_CYCLES)) dut (
        .clk(clk), .rst(rst), .exPC(exPC), .exRS1(exRS1), .exRS2(exRS2),
        .exImmediate(exImmediate), .exALUSrc(exALUSrc), .exALUCtrl(exALUCtrl),
        .exReadDir1(exReadDir1), .exReadDir2(exReadDir2),
        .memWriteDir(memWriteDir), .memRegWrite(memRegWrite), .memALUResult(memALUResult),
        .wbWriteDir(wbWriteDir), .wbRegWrite(wbRegWrite), .wbWriteData(wbWriteData),
        .flush(flush), .aluResult(aluResult), .aluZero(aluZero),
        .branchTarget(branchTarget), .storeData(storeData), .stall(stall)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwd(input stim_t s, input logic [4:0] d, input logic [31:0] v);
        if (s.mrw && s.mdir != 0 && s.mdir == d) return s.mres;
        if (s.wrw && s.wdir != 0 && s.wdir == d) return s.wdata;
        return v;
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t e;
        logic [31:0] a, b;
        longint sa, sb, ubs;
        longint unsigned ua, ub;
        logic [63:0] p;
        logic special;
        a = fwd(s, s.d1, s.rs1);
        e.store = fwd(s, s.d2, s.rs2);
        b = s.alusrc ? s.imm : e.store;
        e.op = s.op;
        e.target = s.pc + s.imm;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        ubs = ub;
        special = (b == 0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF &&
                               (s.op == 14 || s.op == 16));
        p = 0;
        case (s.op)
            0:  e.result = a + b;
            1:  e.result = a - b;
            2:  e.result = a & b;
            3:  e.result = a | b;
            4:  e.result = a ^ b;
            5:  e.result = a << b[4:0];
            6:  e.result = a >> b[4:0];
            7:  begin p = sa >>> b[4:0]; e.result = p[31:0]; end
            8:  e.result = (sa < sb) ? 1 : 0;
            9:  e.result = (a < b) ? 1 : 0;
            10: begin p = sa * sb;  e.result = p[31:0];  end
            11: begin p = sa * sb;  e.result = p[63:32]; end
            12: begin p = sa * ubs; e.result = p[63:32]; end
            13: begin p = ua * ub;  e.result = p[63:32]; end
            14: begin
                if (b == 0) e.result = 32'hFFFF_FFFF;
                else begin p = sa / sb; e.result = p[31:0]; end
            end
            15: e.result = (b == 0) ? 32'hFFFF_FFFF : a / b;
            16: begin
                if (b == 0) e.result = a;
                else begin p = sa % sb; e.result = p[31:0]; end
            end
            17: e.result = (b == 0) ? a : a % b;
            default: e.result = 0;
        endcase
        if (s.op >= 10 && s.op <= 13) e.stalls = MD_CYCLES + 1;
        else if (s.op >= 14 && s.op <= 17) e.stalls = special ? 1 : MD_CYCLES + 1;
        else e.stalls = 0;
        return e;
    endfunction

    // ---------------- driver ----------------
    function automatic stim_t make_stim(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        stim_t s;
        s.op = op; s.pc = $urandom(); s.rs1 = a; s.rs2 = b; s.imm = $urandom();
        s.alusrc = 1'b0; s.d1 = 5'd1; s.d2 = 5'd2; s.mdir = 5'd0; s.wdir = 5'd0;
        s.mrw = 1'b0; s.wrw = 1'b0; s.mres = $urandom(); s.wdata = $urandom();
        return s;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 40);
            default: return $urandom();
        endcase
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        int r;
        r = $urandom_range(0, 21);
        s = make_stim((r > 17) ? 5'($urandom_range(18, 31)) : 5'(r), rnd_val(), rnd_val());
        s.imm = rnd_val();
        s.alusrc = ($urandom_range(0, 3) == 0);
        s.d1 = 5'($urandom_range(0, 3)); s.d2 = 5'($urandom_range(0, 3));
        s.mdir = 5'($urandom_range(0, 3)); s.wdir = 5'($urandom_range(0, 3));
        s.mrw = 1'($urandom_range(0, 1)); s.wrw = 1'($urandom_range(0, 1));
        s.mres = rnd_val(); s.wdata = rnd_val();
        return s;
    endfunction

    task automatic drive(input stim_t s);
        exALUCtrl = s.op; exPC = s.pc; exRS1 = s.rs1; exRS2 = s.rs2;
        exImmediate = s.imm; exALUSrc = s.alusrc; exReadDir1 = s.d1; exReadDir2 = s.d2;
        memWriteDir = s.mdir; memRegWrite = s.mrw; memALUResult = s.mres;
        wbWriteDir = s.wdir; wbRegWrite = s.wrw; wbWriteData = s.wdata;
    endtask

    // Present one instruction and hold it until the monitor sees it complete
    task automatic issue(input stim_t s);
        drive(s);
        exp_q.push_back(model(s));
        accepted = 1'b0;
        instr_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (accepted) break;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL timeout op=%0d: no completion in 100 cycles, stall=%b", s.op, stall);
            exp_q.delete();
        end
        instr_valid = 1'b0;
        stall_cnt = 0;
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (instr_valid && !accepted) begin
            if (stall) begin
                stall_cnt++;
            end else begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: result with empty expected queue, got %h", aluResult);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("result op%0d", e.op), aluResult, e.result);
                    check($sformatf("zero op%0d", e.op), {31'b0, aluZero}, {31'b0, e.result == 0});
                    check($sformatf("store op%0d", e.op), storeData, e.store);
                    check($sformatf("target op%0d", e.op), branchTarget, e.target);
                    check($sformatf("stall_cycles op%0d", e.op), stall_cnt, e.stalls);
                end
                stall_cnt = 0;
                accepted = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : main
        stim_t s;
        exp_t  e;
        flush = 1'b0;

        // Reset state: stall forced low, FSM idle, combinational paths live
        s = make_stim(ALU_DIV, 32'd100, 32'd3);
        drive(s);
        #1;
        e = model(s);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_state", dut.md_state, MD_IDLE);
        check("rst_target", branchTarget, e.target);
        check("rst_store", storeData, e.store);
        check("rst_md_result", aluResult, 32'd0);
        s = make_stim(ALU_XOR, 32'h1234_5678, 32'h0F0F_0F0F);
        drive(s);
        #1;
        e = model(s);
        check("rst_alu_comb", aluResult, e.result);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // ADD wrapping to zero
        s = make_stim(ALU_ADD, 32'd5, 32'd0);
        s.alusrc = 1'b1; s.imm = 32'hFFFF_FFFB;
        issue(s);

        // Forwarding priority and x0
        s = make_stim(ALU_ADD, 32'h99, 32'h7);
        s.alusrc = 1'b1; s.imm = 32'h0; s.d1 = 5'd3;
        s.mdir = 5'd3; s.mrw = 1'b1; s.mres = 32'h10;
        s.wdir = 5'd3; s.wrw = 1'b1; s.wdata = 32'h20;
        issue(s);
        s.d1 = 5'd0; s.mdir = 5'd0; s.wdir = 5'd0;
        issue(s);
        s.d1 = 5'd3; s.d2 = 5'd3; s.mdir = 5'd4; s.wdir = 5'd3;
        issue(s);

        // Multi-cycle ops and special cases
        issue(make_stim(ALU_DIV,    32'hFFFF_FFF9, 32'd2));
        issue(make_stim(ALU_REM,    32'hFFFF_FFF9, 32'd2));
        issue(make_stim(ALU_DIVU,   32'h1234_5678, 32'd0));
        issue(make_stim(ALU_REM,    32'h1234_5678, 32'd0));
        issue(make_stim(ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF));
        issue(make_stim(ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF));
        issue(make_stim(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF));
        issue(make_stim(ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF));
        issue(make_stim(ALU_MULH,   32'h8000_0000, 32'h7FFF_FFFF));
        issue(make_stim(ALU_MULHSU, 32'hFFFF_FFFE, 32'hFFFF_FFFF));
        issue(make_stim(ALU_REMU,   32'd1000,      32'd7));
        issue(make_stim(5'd25,      32'd3,         32'd4));

        // Randomized mix
        for (int n = 0; n < 80; n++) begin
            issue(rnd_stim());
        end

        // Asynchronous reset in the middle of a divide
        s = make_stim(ALU_DIV, 32'd1000, 32'd7);
        drive(s);
        repeat (10) @(posedge clk);
        #2;
        check("pre_rst_stall", {31'b0, stall}, 32'd1);
        check("pre_rst_state", dut.md_state, MD_BUSY);
        rst = 1'b0;
        #1;
        check("midrst_stall", {31'b0, stall}, 32'd0);
        check("midrst_state", dut.md_state, MD_IDLE);
        s = make_stim(ALU_SUB, 32'd10, 32'd3);
        drive(s);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        issue(make_stim(ALU_DIV, 32'd1000, 32'd7));

        // Flush in the middle of a divide, then an ADD must see no stale result
        s = make_stim(ALU_DIVU, 32'hDEAD_BEEF, 32'd9);
        drive(s);
        repeat (5) @(posedge clk);
        #1;
        check("pre_flush_stall", {31'b0, stall}, 32'd1);
        flush = 1'b1;
        #1;
        check("flush_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_state", dut.md_state, MD_IDLE);
        issue(make_stim(ALU_ADD, 32'd40, 32'd2));
        issue(make_stim(ALU_DIVU, 32'hDEAD_BEEF, 32'd9));

        drive(make_stim(ALU_ADD, 32'd0, 32'd0));
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
